// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scanner for an HH:MM clock.
// Each digit slot opens with a guard interval where all anodes are off, then
// shows the digit latched at show entry. Supports blink (per field) and
// hours-tens leading-zero blanking. All display outputs are registered.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 100,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk100Mhz,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic [1:0] blink_sel,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          blink_ph;

    logic          show_entry, show_exit;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_dec, seg_nxt;
    logic          dp_nxt;
    logic          blink_hit, lz_hit;

    // Next-state: guard for GUARD cycles, then show until the slot ends
    always_comb begin
        state_nxt  = state;
        show_entry = 1'b0;
        show_exit  = 1'b0;
        case (state)
            ST_GUARD: if (cnt == GUARD_LAST) begin
                state_nxt  = ST_SHOW;
                show_entry = 1'b1;
            end
            ST_SHOW: if (cnt == CNT_LAST) begin
                state_nxt = ST_GUARD;
                show_exit = 1'b1;
            end
            default: state_nxt = ST_GUARD;
        endcase
    end

    // Pulses during the last show cycle of digit3, i.e. the cycle whose edge wraps 3->0
    assign frame_tick = show_exit && (idx == 2'd3);

    // Digit select, BCD decode and blanking priority (blink > leading zero > decode)
    always_comb begin
        cur_digit = digit0;
        case (idx)
            2'd0: cur_digit = digit0;
            2'd1: cur_digit = digit1;
            2'd2: cur_digit = digit2;
            2'd3: cur_digit = digit3;
            default: cur_digit = digit0;
        endcase
        seg_dec = 7'b0111111;
        case (cur_digit)
            4'd0: seg_dec = 7'b1000000;
            4'd1: seg_dec = 7'b1111001;
            4'd2: seg_dec = 7'b0100100;
            4'd3: seg_dec = 7'b0110000;
            4'd4: seg_dec = 7'b0011001;
            4'd5: seg_dec = 7'b0010010;
            4'd6: seg_dec = 7'b0000010;
            4'd7: seg_dec = 7'b1111000;
            4'd8: seg_dec = 7'b0000000;
            4'd9: seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
        blink_hit = blink_ph && (idx[1] ? blink_sel[1] : blink_sel[0]);
        lz_hit    = lz_blank && (idx == 2'd3) && (cur_digit == 4'd0);
        seg_nxt   = seg_dec;
        dp_nxt    = ~dp_mask[idx];
        if (blink_hit) begin
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end else if (lz_hit) begin
            seg_nxt = 7'b1111111;
        end
    end

    // State register
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) state <= ST_GUARD;
        else     state <= state_nxt;
    end

    // Slot counter: 0..REFRESH_DIV-1, wraps at every slot end
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

    // Digit index advances as each show ends
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst)            idx <= 2'd0;
        else if (show_exit) idx <= idx + 2'd1;
    end

    // Frame counter and blink phase, stepped on each 3->0 wrap
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            fcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (frame_tick) begin
            if (fcnt == FRM_LAST) begin
                fcnt     <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Display registers: load the digit at show entry, blank at show exit
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (show_entry) begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end else if (show_exit) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed phases plus random input churn, checked
// every cycle against a timeline model computed from the elapsed cycle count.
module tb_disp_scan_ctrl;

    localparam int RD = 10;
    localparam int GD = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3, dp_mask;
    logic [1:0] blink_sel;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int t      = 0;
    bit rnd    = 0;

    // inputs as seen by the DUT on the edge entering show
    logic [3:0] s_d [4];
    logic [3:0] s_dpm;
    logic [1:0] s_bsel;
    logic       s_lz;

    disp_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
        .clk100Mhz(clk), .rst(rst),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_mask(dp_mask), .blink_sel(blink_sel), .lz_blank(lz_blank),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d got %b exp %b", tag, t, got, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        check({tag, "_an"},  7'(an),  7'h0F);
        check({tag, "_seg"}, seg,     7'h7F);
        check({tag, "_dp"},  7'(dp),  7'h01);
        check({tag, "_ft"},  7'(frame_tick), 7'h00);
    endtask

    task automatic churn();
        case ($urandom_range(7))
            0: digit0    = 4'($urandom_range(15));
            1: digit1    = 4'($urandom_range(15));
            2: digit2    = 4'($urandom_range(15));
            3: digit3    = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
            4: dp_mask   = 4'($urandom_range(15));
            5: blink_sel = 2'($urandom_range(3));
            6: lz_blank  = 1'($urandom_range(1));
            default: ;
        endcase
    endtask

    // One clock cycle: optional input churn, model check at negedge, advance
    task automatic step();
        int pos, slot, idx, ph;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_ft, bl;
        if (rnd && $urandom_range(2) == 0) churn();
        if (t % RD == GD - 1) begin
            s_d[0] = digit0; s_d[1] = digit1; s_d[2] = digit2; s_d[3] = digit3;
            s_dpm = dp_mask; s_bsel = blink_sel; s_lz = lz_blank;
        end
        @(negedge clk);
        pos  = t % RD;
        slot = t / RD;
        idx  = slot % 4;
        ph   = ((slot / 4) / BF) % 2;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        e_ft = (idx == 3) && (pos == RD - 1);
        if (pos >= GD) begin
            e_an = ~(4'b0001 << idx);
            bl = (ph == 1) && ((idx >= 2) ? s_bsel[1] : s_bsel[0]);
            if (!bl) begin
                e_dp = ~s_dpm[idx];
                if (idx == 3 && s_lz && s_d[3] == 4'd0) e_seg = 7'h7F;
                else                                    e_seg = bcd7(s_d[idx]);
            end
        end
        check("an",  7'(an),  7'(e_an));
        check("seg", seg,     e_seg);
        check("dp",  7'(dp),  7'(e_dp));
        check("ft",  7'(frame_tick), 7'(e_ft));
        @(posedge clk); #1;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit hit;
        digit0 = 4'd4; digit1 = 4'd3; digit2 = 4'd2; digit3 = 4'd1;
        dp_mask = 4'b0000; blink_sel = 2'b00; lz_blank = 1'b0;

        // reset state, held over several edges
        repeat (3) @(posedge clk);
        #1;
        chk_blank("reset");
        rst = 1'b0;
        t = 0;

        // basic scan with 4,3,2,1
        run(60);

        // leading-zero blank on/off for digit3
        digit3 = 4'd0; lz_blank = 1'b1;
        run(40);
        lz_blank = 1'b0;
        run(40);

        // invalid BCD on digit1 with its decimal point
        digit1 = 4'hC; dp_mask = 4'b0010;
        run(40);

        // hours blink across several blink periods
        blink_sel = 2'b10;
        run(180);
        blink_sel = 2'b11;
        run(170);

        // random input churn, including mid-slot changes
        rnd = 1;
        run(600);

        // reset mid-show of digit2
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if ((t / RD) % 4 == 2 && t % RD == 5) hit = 1;
            else step();
        end
        n_chk++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL reach_digit2 got %0d exp 1", hit);
        end
        check("pre_rst_an", 7'(an), 7'h0B);
        rst = 1'b1;
        #1;
        chk_blank("async_rst");
        repeat (3) @(posedge clk);
        #1;
        chk_blank("held_rst");
        rst = 1'b0;
        t = 0;
        run(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk100Mhz cycles per digit slot (0.5 ms at 100 MHz).
REQ-002 Parameter GUARD, default 100, anode-off cycles at the start of each slot; legal range 1 <= GUARD < REFRESH_DIV.
REQ-003 Parameter BLINK_FRAMES, default 125, frames per blink half-period (250 ms at defaults).
REQ-004 clk100Mhz  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 digit0..digit3  in  4 each  BCD values; digit0 = minutes ones, digit1 = minutes tens, digit2 = hours ones, digit3 = hours tens.
REQ-007 dp_mask  in  4  decimal-point enable; bit n applies to digit n.
REQ-008 blink_sel  in  2  blink field select: 00 none, 01 minutes (digits 0-1), 10 hours (digits 2-3), 11 all.
REQ-009 lz_blank  in  1  leading-zero blank enable for digit3.
REQ-010 an  out  4  anode drive, active-low, one-hot-low or all-high.
REQ-011 seg  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 frame_tick  out  1  one-cycle pulse at the end of every 4-digit frame.

Function
REQ-014 The FSM SHALL have two states: GUARD and SHOW. One slot = GUARD state for GUARD cycles, then SHOW state for REFRESH_DIV-GUARD cycles.
REQ-015 The slot counter SHALL be sized to hold REFRESH_DIV-1, count 0..REFRESH_DIV-1, and wrap to 0 at the end of every slot.
REQ-016 In GUARD: an = 1111, seg = 1111111, dp = 1.
REQ-017 In SHOW: an bit for the current index SHALL be 0 and the other bits 1; seg and dp SHALL show that digit.
REQ-018 The digit index (2 bits) SHALL advance 0->1->2->3->0 on the last cycle of each SHOW, with entry to GUARD.
REQ-019 The current digit and its dp_mask bit SHALL be latched on GUARD->SHOW entry and held for the whole SHOW.
REQ-020 an, seg and dp SHALL be registered and change on the same edge as the state/index change.
REQ-021 Decode: BCD 0-9 SHALL use standard segments (0 = 1000000, 4 = 0011001, 8 = 0000000). Values 10-15 SHALL give a dash (seg = 0111111).
REQ-022 If lz_blank = 1 and latched digit3 = 0, seg SHALL be 1111111 during digit3 SHOW. an is still driven and dp follows dp_mask.
REQ-023 A frame counter SHALL increment on each 3->0 index wrap. Blink phase SHALL toggle, and the counter clear, when it reaches BLINK_FRAMES-1 at a wrap.
REQ-024 While blink phase = 1, digits selected by blink_sel SHALL show seg = 1111111 and dp = 1.
REQ-025 Blink phase, blink_sel and lz_blank SHALL be sampled at SHOW entry. Changes during a slot SHALL take effect from the next slot.
REQ-026 frame_tick SHALL be 1 for exactly the one cycle whose edge performs the 3->0 wrap, and 0 otherwise.
REQ-027 Blanking SHALL have priority blink > leading-zero > decode.

Reset
REQ-028 On rst = 1, immediately and without a clock: state = GUARD, index = 0, slot and frame counters = 0, blink phase = 0, an = 1111, seg = 1111111, dp = 1, frame_tick = 0.
REQ-029 After rst falls, the first slot SHALL begin at count 0 in GUARD for digit0. Reset asserted mid-SHOW SHALL abort the slot with no partial-slot carry-over.

Verification (REFRESH_DIV = 10, GUARD = 2, BLINK_FRAMES = 2)
REQ-030 Release reset with digits = 4,3,2,1 -> an = 1111 for 2 cycles, then an = 1110 with seg = 0011001 for 8 cycles, then an = 1111 for 2 cycles, then an = 1101.
REQ-031 Free-run -> frame_tick pulses every 40 cycles, each pulse 1 cycle wide, coincident with the an 0111->1111 transition.
REQ-032 digit3 = 0: lz_blank = 1 -> seg = 1111111 while an = 0111; lz_blank = 0 -> seg = 1000000.
REQ-033 digit1 = 4'hC, dp_mask = 0010 -> seg = 0111111 and dp = 0 while an = 1101.
REQ-034 blink_sel = 10 -> frames 0-1 show digits 2-3 normally, frames 2-3 show seg = 1111111 and dp = 1 on digits 2-3, digits 0-1 unaffected; the pattern repeats every 4 frames.
REQ-035 Assert rst for 3 cycles mid-SHOW of digit2 -> an = 1111 asynchronously within the same cycle; after release, 2 GUARD cycles, then an = 1110.
